// File: rtl/counters_pkg.sv
// Shared COUNTERS library definitions: the all-ones limit and binary/Gray conversion helpers.
// Functions work at MAX_WIDTH; callers truncate the result to their own counter width.
package counters_pkg;

    localparam int MAX_WIDTH = 32;
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down recovers binary from Gray.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = g;
        for (int s = 1; s < MAX_WIDTH; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and result bundle of the Gray counter; master drives controls, slave is the counter.
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             tc;

    modport master (
        output en, up, load, load_val,
        input  bin_out, gray_out, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output bin_out, gray_out, tc
    );
endinterface

// File: rtl/gray_counter_bin2gray.sv
// Combinational binary-to-Gray encoder, zero latency, no flow control.
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with load, wrap/saturate and terminal-count pulse; 1-cycle latency.
// Outputs are registered; controls are sampled every edge with no backpressure.
module gray_counter
    import counters_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter bit              WRAP      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL    = ALL_ONES[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             tc_q;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             tc_nxt;

    always_comb begin
        bin_nxt = bin_q;
        tc_nxt  = 1'b0;
        if (bus.load) begin
            bin_nxt = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (bin_q == MAX_VAL) begin
                    tc_nxt  = 1'b1;
                    bin_nxt = WRAP ? '0 : MAX_VAL;
                end else begin
                    bin_nxt = bin_q + WIDTH'(1);
                end
            end else begin
                if (bin_q == '0) begin
                    tc_nxt  = 1'b1;
                    bin_nxt = WRAP ? MAX_VAL : '0;
                end else begin
                    bin_nxt = bin_q - WIDTH'(1);
                end
            end
        end
    end

    // Gray is encoded from the next binary value so gray_out is a clean flop output.
    bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
        .bin  (bin_nxt),
        .gray (gray_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= RESET_VAL;
            gray_q <= RESET_GRAY;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
            tc_q   <= tc_nxt;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.tc       = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three instances (4-bit wrap, 4-bit saturate, 8-bit wrap with RESET_VAL 0x40)
// share one clock; a reference model pushes expected outputs per edge, checked after the edge.
module tb_gray_counter;
    import counters_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NDUT = 3;
    int W  [NDUT] = '{4, 4, 8};
    int WR [NDUT] = '{1, 0, 1};
    int RV [NDUT] = '{0, 0, 'h40};

    logic [NDUT-1:0] rst_v, en_v, up_v, load_v;
    logic [7:0]      lv_v [NDUT];

    gray_counter_if #(.WIDTH(4)) b0 ();
    gray_counter_if #(.WIDTH(4)) b1 ();
    gray_counter_if #(.WIDTH(8)) b2 ();

    assign b0.en = en_v[0];  assign b0.up = up_v[0];  assign b0.load = load_v[0];  assign b0.load_val = lv_v[0][3:0];
    assign b1.en = en_v[1];  assign b1.up = up_v[1];  assign b1.load = load_v[1];  assign b1.load_val = lv_v[1][3:0];
    assign b2.en = en_v[2];  assign b2.up = up_v[2];  assign b2.load = load_v[2];  assign b2.load_val = lv_v[2];

    gray_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'h0)) u0 (.clk(clk), .rst_n(rst_v[0]), .bus(b0));
    gray_counter #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(4'h0)) u1 (.clk(clk), .rst_n(rst_v[1]), .bus(b1));
    gray_counter #(.WIDTH(8), .WRAP(1'b1), .RESET_VAL(8'h40)) u2 (.clk(clk), .rst_n(rst_v[2]), .bus(b2));

    typedef struct {
        logic [7:0] bin;
        logic [7:0] gray;
        logic       tc;
        int         tog;
    } exp_t;

    exp_t sb[$];
    int   m_bin [NDUT];
    logic [7:0] prev_gray [NDUT];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic obs(input int d, output logic [7:0] bin, output logic [7:0] gray, output logic tc);
        case (d)
            0:       begin bin = {4'h0, b0.bin_out}; gray = {4'h0, b0.gray_out}; tc = b0.tc; end
            1:       begin bin = {4'h0, b1.bin_out}; gray = {4'h0, b1.gray_out}; tc = b1.tc; end
            default: begin bin = b2.bin_out;         gray = b2.gray_out;         tc = b2.tc; end
        endcase
    endtask

    task automatic drive(input int d, input logic r, input logic e, input logic u,
                         input logic l, input logic [7:0] v);
        rst_v[d] = r; en_v[d] = e; up_v[d] = u; load_v[d] = l; lv_v[d] = v;
    endtask

    // One clock edge: model every instance, push expectations, then pop and compare after the edge.
    task automatic cycle(input string tag);
        logic [7:0] ob, og;
        logic       ot;
        for (int d = 0; d < NDUT; d++) begin
            exp_t e;
            int   mx, b, old;
            mx  = (1 << W[d]) - 1;
            b   = m_bin[d];
            old = b;
            e.tc  = 1'b0;
            e.tog = -1;
            if (!rst_v[d]) begin
                b = RV[d];
            end else if (load_v[d]) begin
                b = int'(lv_v[d]) & mx;
            end else begin
                if (en_v[d] && up_v[d]) begin
                    if (b == mx) begin e.tc = 1'b1; b = (WR[d] != 0) ? 0 : mx; end
                    else b = b + 1;
                end else if (en_v[d]) begin
                    if (b == 0) begin e.tc = 1'b1; b = (WR[d] != 0) ? mx : 0; end
                    else b = b - 1;
                end
                e.tog = (b != old) ? 1 : 0;
            end
            m_bin[d] = b;
            e.bin  = 8'(b);
            e.gray = 8'(counters_pkg::bin2gray(32'(b)));
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            exp_t e;
            e = sb.pop_front();
            obs(d, ob, og, ot);
            chk($sformatf("%s.d%0d.bin", tag, d), {24'h0, ob}, {24'h0, e.bin});
            chk($sformatf("%s.d%0d.gray", tag, d), {24'h0, og}, {24'h0, e.gray});
            chk($sformatf("%s.d%0d.tc", tag, d), {31'h0, ot}, {31'h0, e.tc});
            if (e.tog >= 0)
                chk($sformatf("%s.d%0d.toggles", tag, d), $countones(og ^ prev_gray[d]), e.tog);
            prev_gray[d] = og;
        end
    endtask

    logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    initial begin
        logic [7:0] ob, og;
        logic       ot;
        for (int d = 0; d < NDUT; d++) begin
            m_bin[d] = 0;
            prev_gray[d] = '0;
            drive(d, 1'b0, 1'b1, 1'bx, 1'b1, 8'hA5);
        end
        @(negedge clk);

        // Reset with controls asserted: reset must win.
        repeat (2) cycle("reset");
        obs(0, ob, og, ot);
        chk("reset.bin", {24'h0, ob}, 32'h0);
        chk("reset.gray", {24'h0, og}, 32'h0);
        obs(2, ob, og, ot);
        chk("reset8.gray", {24'h0, og}, 32'h60);

        for (int d = 0; d < NDUT; d++) drive(d, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Full up cycle with wrap on the 4-bit wrapping instance.
        drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            cycle("up");
            obs(0, ob, og, ot);
            chk($sformatf("up.gseq%0d", k), {28'h0, og[3:0]}, {28'h0, gseq[k % 16]});
            chk($sformatf("up.tc%0d", k), {31'h0, ot}, (k == 16) ? 32'h1 : 32'h0);
        end

        // Down wrap from 0.
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle("down_wrap");
        obs(0, ob, og, ot);
        chk("down_wrap.bin", {24'h0, ob}, 32'hF);
        chk("down_wrap.gray", {24'h0, og}, 32'h8);
        chk("down_wrap.tc", {31'h0, ot}, 32'h1);
        cycle("down_next");
        obs(0, ob, og, ot);
        chk("down_next.bin", {24'h0, ob}, 32'hE);
        chk("down_next.tc", {31'h0, ot}, 32'h0);

        // Load wins over en.
        drive(0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0A);
        cycle("load");
        obs(0, ob, og, ot);
        chk("load.bin", {24'h0, ob}, 32'hA);
        chk("load.gray", {24'h0, og}, 32'hF);
        drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        cycle("load_up");
        obs(0, ob, og, ot);
        chk("load_up.bin", {24'h0, ob}, 32'hB);
        chk("load_up.gray", {24'h0, og}, 32'hE);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Saturating instance: hold at max with tc high, then step down.
        drive(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F);
        cycle("sat_load");
        drive(1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) begin
            cycle("sat_hold");
            obs(1, ob, og, ot);
            chk("sat_hold.bin", {24'h0, ob}, 32'hF);
            chk("sat_hold.tc", {31'h0, ot}, 32'h1);
        end
        drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle("sat_down");
        obs(1, ob, og, ot);
        chk("sat_down.bin", {24'h0, ob}, 32'hE);
        chk("sat_down.tc", {31'h0, ot}, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // 8-bit instance: count to 0x93, then reset together with load.
        drive(2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h90);
        cycle("w8_load");
        drive(2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) cycle("w8_up");
        obs(2, ob, og, ot);
        chk("w8_at93.bin", {24'h0, ob}, 32'h93);
        drive(2, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
        cycle("w8_rst");
        obs(2, ob, og, ot);
        chk("w8_rst.bin", {24'h0, ob}, 32'h40);
        chk("w8_rst.gray", {24'h0, og}, 32'h60);
        drive(2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        cycle("w8_resume");
        obs(2, ob, og, ot);
        chk("w8_resume.bin", {24'h0, ob}, 32'h41);
        chk("w8_resume.gray", {24'h0, og}, 32'h61);
        chk("w8_resume.g2b", counters_pkg::gray2bin({24'h0, og}), 32'h41);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised synchronous Gray-code counter for the COUNTERS library, the successor to the fixed 4-bit binary-to-Gray converter. It keeps an internal binary count and presents registered binary and Gray outputs. It supports enable, up/down direction, synchronous load, wrap or saturate mode, and a terminal-count pulse. It is intended for clock-domain-crossing pointers and low-toggle position counters.

## Interface
- WIDTH, 4: counter width in bits, ≥ 2
- WRAP, 1: 1 = wrap at limits; 0 = saturate at limits
- RESET_VAL, 0: binary value loaded on reset, < 2^WIDTH
- clk  input  1  single clock; all logic samples on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when stepping
- load  input  1  synchronous load request
- load_val  input  WIDTH  binary value taken on load
- bin_out  output  WIDTH  registered binary count
- gray_out  output  WIDTH  registered Gray code of the count; equals bin_out ^ (bin_out >> 1)
- tc  output  1  registered terminal-count pulse

## Operation
- Priority per rising edge:
  - !rst_n
  - load
  - en
  - hold
- Reset (rst_n low at the edge):
  - bin_out = RESET_VAL
  - gray_out = RESET_VAL ^ (RESET_VAL >> 1)
  - tc = 0
  - en, up and load are ignored.
- Load: bin_out = load_val, gray_out = Gray(load_val), tc = 0. Ignores en and up.
- Step up (en & up): next = bin_out + 1, modulo 2^WIDTH.
  - At bin_out = 2^WIDTH−1: WRAP=1 gives next = 0 and tc = 1. WRAP=0 holds at max and sets tc = 1.
- Step down (en & !up): next = bin_out − 1.
  - At bin_out = 0: WRAP=1 gives next = 2^WIDTH−1 and tc = 1. WRAP=0 holds at 0 and sets tc = 1.
- Every other step or hold sets tc = 0.
- Gray encoding: gray_out is registered from the next binary value, not decoded from bin_out after the flop.
  - Any single step changes exactly one gray_out bit, including the wrap steps.
  - A saturated hold changes none.
- Arithmetic is unsigned. No intermediate value wider than WIDTH+1 bits.
- X on en, up or load while rst_n is low does not propagate.

## Timing
- Latency from a sampled input to the outputs is 1 cycle. No combinational path from inputs to outputs.
- tc is high for exactly the one cycle after the limit step. Continuous en at a saturated limit keeps tc high every cycle.
- Direction change takes effect on the next enabled edge. No dead cycle.
- Reset mid-count: the next edge forces the reset values regardless of load or en. Counting resumes on the first edge where rst_n is high.
- load and en high together: load wins and tc = 0.

## Structure
- Shared package counters_pkg:
  - function bin2gray(WIDTH-generic)
  - function gray2bin, used by the bench only
  - localparam for the all-ones max value
- One sub-module, bin2gray, combinational and parametrised by WIDTH. It is instantiated once on the next-state binary value ahead of the gray_out register.
- The counter's next-state logic and registers stay in gray_counter.

## Test plan
- Reset (WIDTH=4, RESET_VAL=0): hold rst_n=0 for 2 edges → bin_out=0000, gray_out=0000, tc=0.
- Up count, WRAP=1: en=1, up=1 for 16 edges.
  - gray_out follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - tc=1 only in the cycle after 1000→0000.
  - Exactly one gray bit toggles per edge.
- Down wrap: from 0, en=1, up=0 → bin_out=1111, gray_out=1000, tc=1 for one cycle. The next step gives bin_out=1110, tc=0.
- Load priority: load=1, load_val=1010 with en=1 → bin_out=1010, gray_out=1111, tc=0. The next up step gives 1011/1110.
- Saturate (WRAP=0): at 1111 with en=1, up=1 for 3 edges → bin_out stays 1111 and tc stays 1. up=0 → 1110 and tc=0.
- Reset mid-count (WIDTH=8, RESET_VAL=8'h40): count to 8'h93, then drive rst_n=0 together with load=1 → bin_out=8'h40, gray_out=8'h60. Release rst_n → next up step gives 8'h41/8'h61.
